// File: rtl/pkt_asm_pkg.sv
// ---------------------------------------------------------------------------
// pkt_asm_pkg
// Shared types and defaults for the pixel packet assembler.
//   state_t              : assembler FSM states (HUNT, COLLECT, FLUSH)
//   SYNC_BYTE_DEFAULT    : default frame start marker
//   FRAME_PIXELS_DEFAULT : default pixels per frame (240*170)
//   addr_w(n)            : address width needed to index n pixels
// ---------------------------------------------------------------------------
package pkt_asm_pkg;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      COLLECT = 2'd1,
      FLUSH   = 2'd2
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT    = 8'hAA;
   localparam int         FRAME_PIXELS_DEFAULT = 40800;

   // A one-pixel frame would need a zero-width address; keep at least 1 bit.
   function automatic int addr_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pkt_timeout_cnt.sv
// ---------------------------------------------------------------------------
// pkt_timeout_cnt
// Counts idle cycles between bytes inside a frame.
//   clk     : system clock
//   reset   : asynchronous, active-low reset
//   clr     : clear the count (a byte was taken, or not collecting)
//   en      : count this cycle (collecting and no byte available)
//   expired : high for the cycle that is the TIMEOUT_CYC-th idle cycle
// ---------------------------------------------------------------------------
module pkt_timeout_cnt #(
   parameter int TIMEOUT_CYC = 2_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int                CNT_W    = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // clr has priority so a pop in the expiry cycle always wins.
   assign expired = en && !clr && (cnt_q == LAST_CNT);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = expired ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/pixel_packet_assembler.sv
// ---------------------------------------------------------------------------
// pixel_packet_assembler
// Drains a first-word-fall-through byte FIFO, hunts for a sync byte, then
// packs BYTES_PER_PIX bytes (first byte in the MSBs) into one pixel and
// writes each pixel to consecutive frame RAM addresses.
//   clk         : system clock
//   reset       : asynchronous, active-low reset
//   empty       : FIFO empty
//   pop_data    : FIFO head byte, valid while empty is low
//   pop         : consume head byte this cycle (combinational)
//   pixel_we    : one-cycle frame RAM write strobe
//   pixel_data  : assembled pixel
//   pixel_addr  : frame RAM address
//   frame_done  : one-cycle pulse after the last write of a frame
//   busy        : high from sync accepted until frame end or abort
//   err_timeout : sticky inter-byte timeout flag, cleared at next sync
//   frame_cnt   : completed frames, wraps
// ---------------------------------------------------------------------------
module pixel_packet_assembler
   import pkt_asm_pkg::*;
#(
   parameter  int         BYTES_PER_PIX = 3,
   parameter  int         FRAME_PIXELS  = FRAME_PIXELS_DEFAULT,
   parameter  logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT,
   parameter  int         TIMEOUT_CYC   = 2_000_000,
   localparam int         PIX_W         = 8 * BYTES_PER_PIX,
   localparam int         ADDR_W        = addr_w(FRAME_PIXELS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              empty,
   input  logic [7:0]        pop_data,
   output logic              pop,
   output logic              pixel_we,
   output logic [PIX_W-1:0]  pixel_data,
   output logic [ADDR_W-1:0] pixel_addr,
   output logic              frame_done,
   output logic              busy,
   output logic              err_timeout,
   output logic [7:0]        frame_cnt
);

   localparam int                IDX_W     = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
   localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(BYTES_PER_PIX - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [PIX_W-1:0]    pix_q, pix_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                done_q, done_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;
   logic [7:0]          cnt_q, cnt_d;

   logic                pop_ok;
   logic                tmo_clr;
   logic                tmo_en;
   logic                tmo_expired;
   logic [ADDR_W-1:0]   wr_addr;
   logic [PIX_W+7:0]    shift_w;

   assign pop_ok  = ((state_q == HUNT) || (state_q == COLLECT)) && !empty;
   // Gated by reset so every output, pop included, reads 0 while reset is held.
   assign pop     = reset && pop_ok;

   assign tmo_clr = (state_q != COLLECT) || pop_ok;
   assign tmo_en  = (state_q == COLLECT) && empty;

   // Address the pixel being completed now will be written to: the pending
   // increment from a write in this cycle has not landed in addr_q yet.
   assign wr_addr = we_q ? addr_q + ADDR_W'(1) : addr_q;

   // Oldest byte ends up in the MSBs after BYTES_PER_PIX shifts.
   assign shift_w = {pix_q, pop_data};

   pkt_timeout_cnt #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .clr     (tmo_clr),
      .en      (tmo_en),
      .expired (tmo_expired)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pix_d   = pix_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      done_d  = 1'b0;
      busy_d  = busy_q;
      err_d   = err_q;
      cnt_d   = cnt_q;

      case (state_q)
         HUNT: begin
            if (pop_ok && (pop_data == SYNC_BYTE)) begin
               state_d = COLLECT;
               idx_d   = '0;
               addr_d  = '0;
               err_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end

         COLLECT: begin
            if (we_q) begin
               addr_d = addr_q + ADDR_W'(1);
            end
            if (pop_ok) begin
               pix_d = shift_w[PIX_W-1:0];
               if (idx_q == LAST_IDX) begin
                  idx_d = '0;
                  we_d  = 1'b1;
                  // Leave COLLECT as soon as the final byte is taken so no
                  // byte of the next frame is consumed during the last write.
                  if (wr_addr == LAST_ADDR) begin
                     state_d = FLUSH;
                  end
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end else if (tmo_expired) begin
               state_d = HUNT;
               idx_d   = '0;
               addr_d  = '0;
               err_d   = 1'b1;
               busy_d  = 1'b0;
            end
         end

         FLUSH: begin
            // This cycle carries the final pixel_we; frame_done follows it.
            state_d = HUNT;
            done_d  = 1'b1;
            cnt_d   = cnt_q + 8'd1;
            addr_d  = '0;
            busy_d  = 1'b0;
         end

         default: begin
            state_d = HUNT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= HUNT;
         idx_q   <= '0;
         pix_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pix_q   <= pix_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pixel_we    = we_q;
   assign pixel_data  = pix_q;
   assign pixel_addr  = addr_q;
   assign frame_done  = done_q;
   assign busy        = busy_q;
   assign err_timeout = err_q;
   assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_pixel_packet_assembler.sv
// ---------------------------------------------------------------------------
// tb_pixel_packet_assembler
// Three assemblers (3, 2 and 1 bytes per pixel, 4-pixel frames, 100-cycle
// timeout) share one clock and reset; one is selected at a time to receive
// the FIFO stream. Expected writes, frame counts and error flags come from
// a frame-level model built while the stream is queued.
// ---------------------------------------------------------------------------
module tb_pixel_packet_assembler;

   localparam int FP = 4;
   localparam int TO = 100;

   typedef struct {
      bit         stall;
      logic [7:0] b;
      bit         is_sync;
      bit         is_payload;
      bit         completes;
      bit         last_of_frame;
   } ent_t;

   typedef struct {
      logic [31:0] a;
      logic [31:0] d;
   } wr_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       empty_v;
   logic [7:0] pop_data_v;
   int         sel;

   always #5 clk = ~clk;

   logic        e3, e2, e1;
   logic        pop3, pop2, pop1, we3, we2, we1, fd3, fd2, fd1;
   logic        busy3, busy2, busy1, err3, err2, err1;
   logic [23:0] pd3;
   logic [15:0] pd2;
   logic [7:0]  pd1;
   logic [1:0]  pa3, pa2, pa1;
   logic [7:0]  fc3, fc2, fc1;

   assign e3 = (sel == 0) ? empty_v : 1'b1;
   assign e2 = (sel == 1) ? empty_v : 1'b1;
   assign e1 = (sel == 2) ? empty_v : 1'b1;

   pixel_packet_assembler #(.BYTES_PER_PIX(3), .FRAME_PIXELS(FP), .SYNC_BYTE(8'hAA), .TIMEOUT_CYC(TO)) u_dut3 (
      .clk(clk), .reset(reset), .empty(e3), .pop_data(pop_data_v), .pop(pop3),
      .pixel_we(we3), .pixel_data(pd3), .pixel_addr(pa3), .frame_done(fd3),
      .busy(busy3), .err_timeout(err3), .frame_cnt(fc3));

   pixel_packet_assembler #(.BYTES_PER_PIX(2), .FRAME_PIXELS(FP), .SYNC_BYTE(8'hAA), .TIMEOUT_CYC(TO)) u_dut2 (
      .clk(clk), .reset(reset), .empty(e2), .pop_data(pop_data_v), .pop(pop2),
      .pixel_we(we2), .pixel_data(pd2), .pixel_addr(pa2), .frame_done(fd2),
      .busy(busy2), .err_timeout(err2), .frame_cnt(fc2));

   pixel_packet_assembler #(.BYTES_PER_PIX(1), .FRAME_PIXELS(FP), .SYNC_BYTE(8'hAA), .TIMEOUT_CYC(TO)) u_dut1 (
      .clk(clk), .reset(reset), .empty(e1), .pop_data(pop_data_v), .pop(pop1),
      .pixel_we(we1), .pixel_data(pd1), .pixel_addr(pa1), .frame_done(fd1),
      .busy(busy1), .err_timeout(err1), .frame_cnt(fc1));

   logic        pop_o, we_o, fd_o, busy_o, err_o;
   logic [31:0] pd_o;
   logic [1:0]  pa_o;
   logic [7:0]  fc_o;

   always_comb begin
      pop_o = pop1; we_o = we1; fd_o = fd1; busy_o = busy1; err_o = err1;
      pd_o = {24'h0, pd1}; pa_o = pa1; fc_o = fc1;
      case (sel)
         0: begin
            pop_o = pop3; we_o = we3; fd_o = fd3; busy_o = busy3; err_o = err3;
            pd_o = {8'h0, pd3}; pa_o = pa3; fc_o = fc3;
         end
         1: begin
            pop_o = pop2; we_o = we2; fd_o = fd2; busy_o = busy2; err_o = err2;
            pd_o = {16'h0, pd2}; pa_o = pa2; fc_o = fc2;
         end
         default: ;
      endcase
   end

   int   checks = 0;
   int   errors = 0;
   ent_t stream[$];
   wr_t  exp_wr[$];
   int   exp_cnt[3];
   bit   exp_err[3];
   bit   done_pending = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s inst=%0d got=%h exp=%h", tag, sel, got, exp);
      end
   endtask

   // One clock of stream: present the head entry, note whether it is taken,
   // then check the registered outputs just after the edge.
   task automatic step();
      ent_t cur;
      bit   have;
      bit   popped;
      bit   exp_we;
      bit   exp_done;
      wr_t  w;
      @(negedge clk);
      have = 1'b0;
      if (stream.size() > 0 && stream[0].stall) begin
         empty_v = 1'b1;
         void'(stream.pop_front());
      end else if (stream.size() > 0) begin
         have = 1'b1;
         empty_v = 1'b0;
         pop_data_v = stream[0].b;
      end else begin
         empty_v = 1'b1;
      end
      #1;
      popped = 1'b0;
      cur = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
      if (have) begin
         cur = stream[0];
         if (cur.is_payload) check("pop_nobubble", 32'(pop_o), 32'd1);
         if (pop_o) begin
            popped = 1'b1;
            void'(stream.pop_front());
         end
      end
      @(posedge clk);
      #1;
      exp_we = popped && cur.completes;
      exp_done = done_pending;
      done_pending = popped && cur.last_of_frame;
      if (we_o || exp_we) begin
         check("pixel_we", 32'(we_o), 32'(exp_we));
         if (we_o) begin
            $display("WR inst=%0d addr=%0d data=%h", sel, pa_o, pd_o);
            if (exp_wr.size() == 0) begin
               check("wr_extra", 32'd1, 32'd0);
            end else begin
               w = exp_wr.pop_front();
               check("wr_addr", 32'(pa_o), w.a);
               check("wr_data", pd_o, w.d);
            end
         end
      end
      if (fd_o || exp_done) begin
         check("frame_done", 32'(fd_o), 32'(exp_done));
         if (fd_o) $display("FRAME_DONE inst=%0d cnt=%0d", sel, fc_o);
      end
      if (popped && cur.is_sync) begin
         check("busy_after_sync", 32'(busy_o), 32'd1);
         check("err_clr_at_sync", 32'(err_o), 32'd0);
      end
   endtask

   task automatic run_stream();
      int n;
      n = 0;
      while (stream.size() > 0 && n < 3000) begin
         step();
         n++;
      end
      if (stream.size() > 0) begin
         check("stream_budget", 32'(stream.size()), 32'd0);
         stream.delete();
      end
      repeat (3) step();
   endtask

   // Queue junk, a sync byte and payload; record the writes the payload must
   // produce. A short payload is followed by a stall long enough to abort.
   task automatic queue_frame(input logic [7:0] junk[$], input logic [7:0] pay[$],
                              input int max_gap, input bit with_stall);
      ent_t e;
      wr_t  w;
      int   bpp;
      int   ng;
      bpp = 3 - sel;
      foreach (junk[i]) begin
         e = '{1'b0, junk[i], 1'b0, 1'b0, 1'b0, 1'b0};
         stream.push_back(e);
      end
      e = '{1'b0, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0};
      stream.push_back(e);
      for (int i = 0; i < pay.size(); i++) begin
         ng = $urandom_range(max_gap, 0);
         for (int g = 0; g < ng; g++) begin
            e = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
            stream.push_back(e);
         end
         e = '{1'b0, pay[i], 1'b0, 1'b1, ((i + 1) % bpp) == 0, (i + 1) == bpp * FP};
         stream.push_back(e);
         if (((i + 1) % bpp) == 0) begin
            w.a = 32'((i + 1) / bpp - 1);
            w.d = 32'h0;
            for (int j = 0; j < bpp; j++) begin
               w.d = w.d + (32'(pay[i + 1 - bpp + j]) << (8 * (bpp - 1 - j)));
            end
            exp_wr.push_back(w);
         end
      end
      if (with_stall && pay.size() < bpp * FP) begin
         for (int g = 0; g < TO + 5; g++) begin
            e = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
            stream.push_back(e);
         end
      end
   endtask

   task automatic run_frame(input logic [7:0] junk[$], input logic [7:0] pay[$], input int max_gap);
      bit full;
      full = (pay.size() == (3 - sel) * FP);
      queue_frame(junk, pay, max_gap, 1'b1);
      run_stream();
      if (full) exp_cnt[sel] = (exp_cnt[sel] + 1) % 256;
      else      exp_err[sel] = 1'b1;
      if (full) exp_err[sel] = 1'b0;
      check("wr_missing", 32'(exp_wr.size()), 32'd0);
      exp_wr.delete();
      check("frame_cnt", 32'(fc_o), 32'(exp_cnt[sel]));
      check("err_timeout", 32'(err_o), 32'(exp_err[sel]));
      check("busy_idle", 32'(busy_o), 32'd0);
      check("addr_idle", 32'(pa_o), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_pop"}, 32'(pop_o), 32'd0);
      check({tag, "_we"}, 32'(we_o), 32'd0);
      check({tag, "_data"}, pd_o, 32'd0);
      check({tag, "_addr"}, 32'(pa_o), 32'd0);
      check({tag, "_done"}, 32'(fd_o), 32'd0);
      check({tag, "_busy"}, 32'(busy_o), 32'd0);
      check({tag, "_err"}, 32'(err_o), 32'd0);
      check({tag, "_cnt"}, 32'(fc_o), 32'd0);
   endtask

   initial begin
      logic [7:0] junk[$];
      logic [7:0] pay[$];
      logic [7:0] b;
      int         len;

      sel = 0;
      empty_v = 1'b0;
      pop_data_v = 8'hAA;
      for (int k = 0; k < 3; k++) begin
         exp_cnt[k] = 0;
         exp_err[k] = 1'b0;
      end
      #2 reset = 1'b0;
      #2 check_all_zero("rst");
      repeat (3) @(posedge clk);
      @(negedge clk);
      empty_v = 1'b1;
      reset = 1'b1;

      // Directed frame 00..0B
      junk.delete(); pay.delete();
      for (int i = 0; i < 12; i++) pay.push_back(8'(i));
      run_frame(junk, pay, 0);

      // Leading junk is discarded
      junk.push_back(8'h11); junk.push_back(8'h22);
      run_frame(junk, pay, 0);

      // Sync value inside payload is data
      junk.delete(); pay.delete();
      pay.push_back(8'h00); pay.push_back(8'hAA);
      for (int i = 1; i <= 10; i++) pay.push_back(8'(i));
      run_frame(junk, pay, 0);

      // Stalled frame: one write, then abort
      pay.delete();
      for (int i = 0; i < 4; i++) pay.push_back(8'(8'h40 + i));
      run_frame(junk, pay, 0);

      // Full frame after abort clears the error
      pay.delete();
      for (int i = 0; i < 12; i++) pay.push_back(8'($urandom));
      run_frame(junk, pay, 2);

      // Reset mid-frame after sync and 5 bytes
      pay.delete();
      for (int i = 0; i < 5; i++) pay.push_back(8'(8'h60 + i));
      queue_frame(junk, pay, 0, 1'b0);
      while (stream.size() > 0) step();
      check("pre_rst_busy", 32'(busy_o), 32'd1);
      @(negedge clk);
      empty_v = 1'b0;
      pop_data_v = 8'h55;
      reset = 1'b0;
      #1 check_all_zero("midrst");
      check("midrst_wr_done", 32'(exp_wr.size()), 32'd0);
      exp_wr.delete();
      done_pending = 1'b0;
      for (int k = 0; k < 3; k++) begin
         exp_cnt[k] = 0;
         exp_err[k] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      empty_v = 1'b1;
      reset = 1'b1;
      pay.delete();
      for (int i = 0; i < 12; i++) pay.push_back(8'($urandom));
      run_frame(junk, pay, 1);

      // Randomized frames on every pixel width
      for (int s = 0; s < 3; s++) begin
         sel = s;
         for (int f = 0; f < 6; f++) begin
            junk.delete(); pay.delete();
            for (int j = 0; j < $urandom_range(3, 0); j++) begin
               b = 8'($urandom);
               if (b == 8'hAA) b = 8'h3C;
               junk.push_back(b);
            end
            len = (3 - s) * FP;
            if ($urandom_range(3, 0) == 0) len = $urandom_range(len - 1, 0);
            for (int j = 0; j < len; j++) begin
               b = ($urandom_range(7, 0) == 0) ? 8'hAA : 8'($urandom);
               pay.push_back(b);
            end
            run_frame(junk, pay, 3);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
